// File: rtl/cp0_intc_timer.sv
// rtl/cp0_intc_timer.sv - CP0 with external interrupt lines, Count/Compare timer and eret
module cp0_intc_timer #(
    parameter int          HW_INT_N  = 5,
    parameter int          INT_LATCH = 0,
    parameter int          TIMER_EN  = 1,
    parameter int          TIMER_DIV = 1,
    parameter logic [31:0] PRID_VAL  = 32'h0000_5A07
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                we,
    input  logic [4:0]          addr,
    input  logic [31:0]         wdata,
    output logic [31:0]         rdata,
    input  logic [31:0]         pc,
    input  logic                bd,
    input  logic [4:0]          exc_code,
    input  logic [HW_INT_N-1:0] hw_int,
    input  logic                eret,
    output logic                req,
    output logic [31:0]         epc_out,
    output logic                timer_irq
);

    localparam logic [4:0] HW_MASK  = 5'((32'd1 << HW_INT_N) - 32'd1);
    localparam logic [3:0] DIV_LAST = 4'(TIMER_DIV - 1);

    logic [31:0] count, compare, epc;
    logic [3:0]  div_cnt;
    logic [5:0]  im;
    logic        exl, ie, bd_r;
    logic [4:0]  ip_hw;
    logic        ip_tmr;
    logic [4:0]  exccode;

    logic [4:0]  hw_ext;
    logic [5:0]  ip;
    logic        int_req, exc_req, wr_ok;
    logic        wr_count, wr_compare, wr_sr, wr_cause, wr_epc;
    logic        div_wrap, inc, timer_set;
    logic [31:0] count_inc, epc_src;

    assign hw_ext  = 5'(hw_int);
    assign ip      = {ip_tmr, ip_hw};
    assign int_req = (|(ip & im)) & ie & ~exl;
    assign exc_req = (exc_code != 5'd0) & ~exl;
    assign req     = int_req | exc_req;

    // mtc0 loses to both exception entry and eret in the same cycle
    assign wr_ok      = we & ~req & ~eret;
    assign wr_count   = wr_ok && addr == 5'd9;
    assign wr_compare = wr_ok && addr == 5'd11;
    assign wr_sr      = wr_ok && addr == 5'd12;
    assign wr_cause   = wr_ok && addr == 5'd13;
    assign wr_epc     = wr_ok && addr == 5'd14;

    assign count_inc = count + 32'd1;
    assign div_wrap  = (div_cnt == DIV_LAST);
    assign inc       = div_wrap & ~wr_count;
    assign timer_set = inc && (count_inc == compare);
    assign epc_src   = bd ? pc - 32'd4 : pc;

    assign epc_out   = epc;
    assign timer_irq = ip_tmr;

    always_ff @(posedge clk) begin
        if (reset) begin
            count   <= '0;
            compare <= '0;
            div_cnt <= '0;
            im      <= '0;
            exl     <= 1'b0;
            ie      <= 1'b0;
            bd_r    <= 1'b0;
            ip_hw   <= '0;
            ip_tmr  <= 1'b0;
            exccode <= '0;
            epc     <= '0;
        end else begin
            if (INT_LATCH != 0)
                ip_hw <= ((wr_cause ? wdata[14:10] : ip_hw) | hw_ext) & HW_MASK;
            else
                ip_hw <= hw_ext;

            if (TIMER_EN != 0) begin
                if (wr_count) begin
                    count   <= wdata;
                    div_cnt <= '0;
                end else if (div_wrap) begin
                    count   <= count_inc;
                    div_cnt <= '0;
                end else begin
                    div_cnt <= div_cnt + 4'd1;
                end
                if (wr_compare)
                    compare <= wdata;
                // a match on this edge beats a Compare write clearing the bit
                ip_tmr <= timer_set | (ip_tmr & ~wr_compare);
            end

            if (req) begin
                exl     <= 1'b1;
                bd_r    <= bd;
                exccode <= int_req ? 5'd0 : exc_code;
                epc     <= {epc_src[31:2], 2'b00};
            end else if (eret) begin
                exl <= 1'b0;
            end else begin
                if (wr_sr) begin
                    im  <= wdata[15:10];
                    exl <= wdata[1];
                    ie  <= wdata[0];
                end
                if (wr_epc)
                    epc <= {wdata[31:2], 2'b00};
            end
        end
    end

    always_comb begin
        rdata = 32'd0;
        case (addr)
            5'd9:    rdata = count;
            5'd11:   rdata = compare;
            5'd12:   rdata = {16'd0, im, 8'd0, exl, ie};
            5'd13:   rdata = {bd_r, 15'd0, ip, 3'd0, exccode, 2'd0};
            5'd14:   rdata = epc;
            5'd15:   rdata = PRID_VAL;
            default: rdata = 32'd0;
        endcase
    end

endmodule
